// File: rtl/simmem_pkg.sv
// Shared types and helpers for the simulated-memory response path.
// Widths here describe the default 64-entry pool; blocks with other sizes derive their own.
package simmem_pkg;

  localparam int unsigned PkgCapacity    = 64;
  localparam int unsigned PkgPtrWidth    = $clog2(PkgCapacity);
  localparam int unsigned PkgCntWidth    = $clog2(PkgCapacity + 1);
  localparam int unsigned MaxStructWidth = 256;

  typedef logic [PkgPtrWidth-1:0] ptr_t;
  typedef logic [PkgCntWidth-1:0] cnt_t;

  // Returns the ID field held in the top id_width bits of a struct_width-bit struct.
  function automatic logic [31:0] get_struct_id(logic [MaxStructWidth-1:0] data,
                                                int unsigned struct_width,
                                                int unsigned id_width);
    logic [MaxStructWidth-1:0] shifted;
    shifted = data >> (struct_width - id_width);
    return shifted[31:0] & ((32'd1 << id_width) - 32'd1);
  endfunction

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Round-robin arbiter with a grant hold for locked handshakes.
// The search starts one past the last requester that completed a handshake.
module simmem_rr_arbiter #(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         hold_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned IdxWidth = (N > 1) ? $clog2(N) : 1;

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] idx;
  logic [N-1:0]        grant_q;
  logic [N-1:0]        pick;

  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IdxWidth'((int'(ptr_q) + k) % int'(N));
      if (pick == '0 && req_i[idx]) pick[idx] = 1'b1;
    end
  end

  assign grant_o = hold_i ? grant_q : pick;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      if (!hold_i) grant_q <= pick;
      if (advance_i) begin
        for (int k = 0; k < int'(N); k++) begin
          if (grant_o[k]) ptr_q <= IdxWidth'((k + 1) % int'(N));
        end
      end
    end
  end

endmodule

// File: rtl/simmem_linkedlist_buffer.sv
// Per-ID reorder buffer: one FIFO linked list per ID inside a shared pool with a free list,
// released through a round-robin arbiter whose grant is locked until the output handshake.
module simmem_linkedlist_buffer
  import simmem_pkg::*;
#(
  parameter int unsigned StructWidth   = 64,
  parameter int unsigned IDWidth       = 4,
  parameter int unsigned TotalCapacity = 64,
  localparam int unsigned NumIds       = 2 ** IDWidth,
  localparam int unsigned PtrWidth     = $clog2(TotalCapacity),
  localparam int unsigned CntWidth     = $clog2(TotalCapacity + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumIds-1:0]            release_en_i,
  input  logic [StructWidth-1:0]       data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [StructWidth-1:0]       data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NumIds*CntWidth-1:0]   occupancy_o,
  output logic [CntWidth-1:0]          free_cnt_o
);

  localparam int unsigned PayloadWidth = StructWidth - IDWidth;

  logic [PayloadWidth-1:0] payload_q [TotalCapacity];
  logic [PtrWidth-1:0]     next_q    [TotalCapacity];
  logic [TotalCapacity-1:0] valid_q;
  logic [PtrWidth-1:0]     head_q [NumIds];
  logic [PtrWidth-1:0]     head_d [NumIds];
  logic [PtrWidth-1:0]     tail_q [NumIds];
  logic [PtrWidth-1:0]     tail_d [NumIds];
  logic [CntWidth-1:0]     cnt_q  [NumIds];
  logic [CntWidth-1:0]     cnt_d  [NumIds];
  logic [CntWidth-1:0]     free_q;
  logic                    lock_q;

  logic [PtrWidth-1:0] free_slot;
  logic [IDWidth-1:0]  push_id;
  logic [IDWidth-1:0]  pop_id;
  logic                push;
  logic                pop;
  logic [NumIds-1:0]   req;
  logic [NumIds-1:0]   grant;

  // Lowest-index free entry; valid_q is registered so a slot freed now is usable next cycle.
  always_comb begin
    free_slot = '0;
    for (int i = int'(TotalCapacity) - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_slot = PtrWidth'(i);
    end
  end

  assign in_ready_o = rst_ni && (free_q != '0);
  assign push       = in_valid_i && in_ready_o;
  assign push_id    = IDWidth'(get_struct_id(MaxStructWidth'(data_i), StructWidth, IDWidth));

  always_comb begin
    for (int i = 0; i < int'(NumIds); i++) req[i] = release_en_i[i] && (cnt_q[i] != '0);
  end

  simmem_rr_arbiter #(
    .N(NumIds)
  ) u_arbiter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .hold_i   (lock_q),
    .advance_i(pop),
    .grant_o  (grant)
  );

  always_comb begin
    pop_id = '0;
    for (int i = 0; i < int'(NumIds); i++) begin
      if (grant[i]) pop_id = IDWidth'(i);
    end
  end

  assign out_valid_o = rst_ni && (|grant);
  assign pop         = out_valid_o && out_ready_i;
  assign data_o      = out_valid_o ? {pop_id, payload_q[head_q[pop_id]]} : '0;
  assign free_cnt_o  = rst_ni ? free_q : CntWidth'(TotalCapacity);

  always_comb begin
    for (int i = 0; i < int'(NumIds); i++) begin
      occupancy_o[i*CntWidth +: CntWidth] = rst_ni ? cnt_q[i] : '0;
    end
  end

  // Pop is applied first so a same-ID push onto a list that just emptied becomes the new head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      head_d[pop_id] = next_q[head_q[pop_id]];
      cnt_d[pop_id]  = cnt_q[pop_id] - CntWidth'(1);
    end
    if (push) begin
      tail_d[push_id] = free_slot;
      if (cnt_d[push_id] == '0) head_d[push_id] = free_slot;
      cnt_d[push_id] = cnt_d[push_id] + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      free_q  <= CntWidth'(TotalCapacity);
      lock_q  <= 1'b0;
      for (int i = 0; i < int'(NumIds); i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (pop) valid_q[head_q[pop_id]] <= 1'b0;
      if (push) valid_q[free_slot] <= 1'b1;
      if (push && !pop) free_q <= free_q - CntWidth'(1);
      else if (pop && !push) free_q <= free_q + CntWidth'(1);
      lock_q <= out_valid_o && !out_ready_i;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      payload_q[free_slot] <= data_i[PayloadWidth-1:0];
      if (cnt_q[push_id] != '0) next_q[tail_q[push_id]] <= free_slot;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push && free_q == '0));
      assert (!(pop && cnt_q[pop_id] == '0));
    end
  end

endmodule

// File: tb/tb_simmem_linkedlist_buffer.sv
// Self-checking bench for simmem_linkedlist_buffer against a per-ID queue model.
module tb_simmem_linkedlist_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  release_en;
  logic [63:0]  data_in;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  data_out;
  logic         out_valid;
  logic         out_ready;
  logic [111:0] occ;
  logic [6:0]   free_cnt;

  int total = 0;
  int bad = 0;

  logic [59:0] q [16][$];
  int          m_rr;
  bit          m_lock;
  logic [3:0]  m_lock_id;

  logic         exp_valid;
  logic         exp_ready;
  logic [3:0]   exp_id;
  logic [63:0]  exp_data;
  logic [111:0] exp_occ;
  logic [6:0]   exp_free;

  always #5 clk = ~clk;

  simmem_linkedlist_buffer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .release_en_i(release_en),
    .data_i      (data_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_o      (data_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .occupancy_o (occ),
    .free_cnt_o  (free_cnt)
  );

  function automatic int model_total();
    int s = 0;
    for (int i = 0; i < 16; i++) s += q[i].size();
    return s;
  endfunction

  function automatic logic [63:0] rand_struct(input logic [3:0] id);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[63:60] = id;
    return r;
  endfunction

  // Drive one cycle's inputs, then derive expected outputs from the model.
  task automatic apply(input logic iv, input logic [63:0] d, input logic [15:0] en,
                       input logic ordy);
    int idx;
    in_valid   = iv;
    data_in    = d;
    release_en = en;
    out_ready  = ordy;
    #1;
    exp_free  = 7'(64 - model_total());
    exp_ready = (model_total() != 64);
    exp_valid = 1'b0;
    exp_id    = 4'd0;
    if (m_lock) begin
      exp_valid = 1'b1;
      exp_id    = m_lock_id;
    end else begin
      for (int k = 0; k < 16; k++) begin
        idx = (m_rr + k) % 16;
        if (!exp_valid && en[idx] && q[idx].size() != 0) begin
          exp_valid = 1'b1;
          exp_id    = 4'(idx);
        end
      end
    end
    exp_data = exp_valid ? {exp_id, q[exp_id][0]} : 64'd0;
    for (int i = 0; i < 16; i++) exp_occ[i*7 +: 7] = 7'(q[i].size());
  endtask

  task automatic tick();
    logic       pushed;
    logic       popped;
    logic [3:0] pid;
    pushed = in_valid && exp_ready;
    popped = exp_valid && out_ready;
    pid    = data_in[63:60];
    @(posedge clk);
    if (popped) begin
      void'(q[exp_id].pop_front());
      m_rr   = (int'(exp_id) + 1) % 16;
      m_lock = 1'b0;
    end else if (exp_valid) begin
      m_lock    = 1'b1;
      m_lock_id = exp_id;
    end
    if (pushed) q[pid].push_back(data_in[59:0]);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) q[i].delete();
    m_rr   = 0;
    m_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    data_in    = rand_struct(4'd1);
    release_en = 16'hFFFF;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || data_out !== 64'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%0b v=%0b d=%h want 0 0 0", in_ready, out_valid, data_out);
    end
    total++;
    if (occ !== 112'd0 || free_cnt !== 7'd64) begin
      bad++;
      $display("FAIL reset_cnt: got occ=%h free=%0d want 0 64", occ, free_cnt);
    end
    total++;
    model_reset();
    rst_n = 1'b1;
    apply(1'b0, 64'd0, 16'hFFFF, 1'b0);
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_first: got rdy=%0b v=%0b want 1 0", in_ready, out_valid);
    end
    total++;
    tick();
  endtask

  task automatic test_basic_order();
    logic [59:0] pl [3];
    pl[0] = 60'hA;
    pl[1] = 60'hB;
    pl[2] = 60'hC;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, {4'd3, pl[i]}, 16'h0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 64'd0, 16'h0008, 1'b1);
      if (out_valid !== 1'b1 || data_out !== {4'd3, pl[i]} || occ[21 +: 7] !== 7'(3 - i)) begin
        bad++;
        $display("FAIL basic_order[%0d]: got v=%0b d=%h occ3=%0d want 1 %h %0d", i, out_valid,
                 data_out, occ[21 +: 7], {4'd3, pl[i]}, 3 - i);
      end
      total++;
      tick();
    end
    apply(1'b0, 64'd0, 16'h0008, 1'b1);
    if (occ[21 +: 7] !== 7'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_empty: got occ3=%0d v=%0b want 0 0", occ[21 +: 7], out_valid);
    end
    total++;
    tick();
  endtask

  task automatic test_reorder();
    logic [63:0] want [3];
    logic [15:0] en [3];
    apply(1'b1, {4'd1, 60'h11}, 16'h0, 1'b0); tick();
    apply(1'b1, {4'd2, 60'h22}, 16'h0, 1'b0); tick();
    apply(1'b1, {4'd1, 60'h12}, 16'h0, 1'b0); tick();
    want[0] = {4'd2, 60'h22}; en[0] = 16'h0004;
    want[1] = {4'd1, 60'h11}; en[1] = 16'h0002;
    want[2] = {4'd1, 60'h12}; en[2] = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 64'd0, en[i], 1'b1);
      if (out_valid !== 1'b1 || data_out !== want[i] || data_out !== exp_data) begin
        bad++;
        $display("FAIL reorder[%0d]: got v=%0b d=%h want 1 %h", i, out_valid, data_out, want[i]);
      end
      total++;
      tick();
    end
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 64; i++) begin
      apply(1'b1, rand_struct(4'($urandom_range(0, 15))), 16'h0, 1'b0);
      tick();
    end
    apply(1'b1, rand_struct(4'd7), 16'h0, 1'b0);
    if (in_ready !== 1'b0 || free_cnt !== 7'd0 || occ !== exp_occ) begin
      bad++;
      $display("FAIL full_state: got rdy=%0b free=%0d want 0 0", in_ready, free_cnt);
    end
    total++;
    tick();
    apply(1'b0, 64'd0, 16'hFFFF, 1'b1);
    if (out_valid !== exp_valid || data_out !== exp_data) begin
      bad++;
      $display("FAIL full_pop: got v=%0b d=%h want %0b %h", out_valid, data_out, exp_valid,
               exp_data);
    end
    total++;
    tick();
    apply(1'b1, rand_struct(4'd9), 16'h0, 1'b0);
    if (in_ready !== 1'b1 || free_cnt !== 7'd1) begin
      bad++;
      $display("FAIL full_refill: got rdy=%0b free=%0d want 1 1", in_ready, free_cnt);
    end
    total++;
    tick();
    apply(1'b0, 64'd0, 16'h0, 1'b0);
    if (in_ready !== 1'b0 || free_cnt !== 7'd0) begin
      bad++;
      $display("FAIL full_again: got rdy=%0b free=%0d want 0 0", in_ready, free_cnt);
    end
    total++;
    tick();
    n = 0;
    while (model_total() != 0 && n < 100) begin
      apply(1'b0, 64'd0, 16'hFFFF, 1'b1);
      if (out_valid !== exp_valid || data_out !== exp_data || free_cnt !== exp_free) begin
        bad++;
        $display("FAIL drain[%0d]: got v=%0b d=%h free=%0d want %0b %h %0d", n, out_valid,
                 data_out, free_cnt, exp_valid, exp_data, exp_free);
      end
      total++;
      tick();
      n++;
    end
    if (model_total() != 0) begin
      bad++;
      $display("FAIL drain_bound: got left=%0d want 0", model_total());
    end
  endtask

  task automatic test_same_id();
    logic [63:0] x;
    logic [63:0] y;
    x = rand_struct(4'd5);
    y = rand_struct(4'd5);
    apply(1'b1, x, 16'h0, 1'b0);
    tick();
    apply(1'b1, y, 16'h0020, 1'b1);
    if (out_valid !== 1'b1 || data_out !== x || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL same_id_pop: got v=%0b d=%h want 1 %h", out_valid, data_out, x);
    end
    total++;
    tick();
    apply(1'b0, 64'd0, 16'h0020, 1'b1);
    if (occ[35 +: 7] !== 7'd1 || data_out !== y || occ !== exp_occ) begin
      bad++;
      $display("FAIL same_id_next: got occ5=%0d d=%h want 1 %h", occ[35 +: 7], data_out, y);
    end
    total++;
    tick();
  endtask

  task automatic test_lock_rr();
    logic [3:0] want_id [4];
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        apply(1'b1, rand_struct(4'(i)), 16'h0, 1'b0);
        tick();
      end
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 64'd0, (c == 0) ? 16'h0007 : 16'h0006, 1'b0);
      if (out_valid !== 1'b1 || data_out[63:60] !== 4'd0 || data_out !== exp_data) begin
        bad++;
        $display("FAIL lock_hold[%0d]: got v=%0b d=%h want id 0 %h", c, out_valid, data_out,
                 exp_data);
      end
      total++;
      tick();
    end
    want_id[0] = 4'd0;
    want_id[1] = 4'd1;
    want_id[2] = 4'd2;
    want_id[3] = 4'd0;
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 64'd0, 16'h0007, 1'b1);
      if (out_valid !== 1'b1 || data_out[63:60] !== want_id[c] || data_out !== exp_data) begin
        bad++;
        $display("FAIL rr_order[%0d]: got id=%0d d=%h want id=%0d", c, data_out[63:60],
                 data_out, want_id[c]);
      end
      total++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, rand_struct(4'($urandom_range(0, 15))), 16'h0, 1'b0);
      tick();
    end
    in_valid   = 1'b1;
    release_en = 16'hFFFF;
    out_ready  = 1'b1;
    do_reset();
    apply(1'b0, 64'd0, 16'hFFFF, 1'b1);
    if (free_cnt !== 7'd64 || occ !== 112'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got free=%0d occ=%h v=%0b want 64 0 0", free_cnt, occ,
               out_valid);
    end
    total++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      apply(1'($urandom_range(0, 3) != 0), rand_struct(4'($urandom_range(0, 5))),
            16'($urandom()) | 16'h0010, 1'($urandom_range(0, 3) != 0));
      if (out_valid !== exp_valid || data_out !== exp_data || in_ready !== exp_ready ||
          free_cnt !== exp_free || occ !== exp_occ) begin
        bad++;
        $display("FAIL random[%0d]: got v=%0b d=%h rdy=%0b free=%0d want %0b %h %0b %0d", c,
                 out_valid, data_out, in_ready, free_cnt, exp_valid, exp_data, exp_ready,
                 exp_free);
      end
      total++;
      tick();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    release_en = 16'h0;
    data_in    = 64'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_order();
    test_reorder();
    test_full();
    test_same_id();
    test_lock_rr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
